uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 frames, LSB first, idle-high line.
- Counterpart of the team's UART transmitter. Default bit period is 10416 clocks (9600 baud at 100 MHz).
- Synchronises the asynchronous RxD line, validates the start bit at mid-bit, and samples each data bit and the stop bit at bit centre.
- Holds the received byte until the consumer acknowledges it. Flags framing and overrun errors.

Parameters:
- CLKS_PER_BIT, 10416: clocks per bit period; legal range >= 8.
- HALF_BIT, CLKS_PER_BIT/2: clocks from start-edge detection to the start-bit centre sample.

Ports:
- clk  input  1  system/UART clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- RxD  input  1  serial input; asynchronous to clk; idle high.
- data  output  8  last accepted byte; stable while rx_full=1.
- rx_full  output  1  byte available; held until data_ack.
- data_ack  input  1  consumer acknowledge; clears rx_full on the same edge.
- framing_err  output  1  one-cycle pulse when the stop bit is sampled low.
- overrun_err  output  1  one-cycle pulse when a good byte completes while rx_full=1 and no ack arrives.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values:
  - data=0, rx_full=0, framing_err=0, overrun_err=0, busy=0, state=IDLE.
  - Both synchroniser flops are set to 1, so no false start after reset.
  - Bit counter=0, baud counter=0, shift register=0.
- Reset mid-frame aborts the frame immediately. No error pulse is produced.
- Synchroniser:
  - Two flops. rxd_s is the output of the second flop.
  - All decisions below use rxd_s (2-cycle input latency).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1, cleared on every state transition.
  - Width is ceil(log2(CLKS_PER_BIT)).
- IDLE:
  - rxd_s==0 -> START, baud counter cleared.
- START:
  - At count==HALF_BIT-1, sample rxd_s.
  - rxd_s==1: glitch; return to IDLE, no flags.
  - rxd_s==0: -> DATA, bit index=0.
- DATA:
  - At count==CLKS_PER_BIT-1, shift rxd_s into the shift register MSB (right shift) and increment bit index.
  - After the 8th sample (index 7) -> STOP.
- STOP: at count==CLKS_PER_BIT-1, sample rxd_s.
  - rxd_s==1 and rx_full==0 (or data_ack==1 this cycle): data<=shift reg, rx_full<=1; -> IDLE.
  - rxd_s==1, rx_full==1 and no data_ack: byte dropped; data keeps the old byte; overrun_err pulses 1 cycle; -> IDLE.
  - rxd_s==0: framing_err pulses 1 cycle; byte discarded; data and rx_full unchanged; -> BREAK.
- BREAK:
  - Wait for rxd_s==1, then -> IDLE. Prevents a held-low line from re-triggering START.
- data_ack:
  - Clears rx_full on the edge it is seen high.
  - Ack while rx_full=0 is ignored.
  - Ack coinciding with a good stop sample: new byte loads, rx_full stays 1, no overrun.
- Latency: rx_full rises 2 + HALF_BIT + 9*CLKS_PER_BIT clocks (+/-1) after the RxD falling edge. This places the stop sample mid-stop-bit.
- busy=1 in START, DATA, STOP and BREAK.
- Sequencing: a new frame may start on the first low rxd_s after returning to IDLE. Back-to-back frames from the transmitter (zero idle gap) must be received.
- Scale: 120-250 lines of RTL.

Test Plan:
- CLKS_PER_BIT=16, send 8'hA5 as 8N1 frame -> rx_full rises once, data=8'hA5, framing_err=0, overrun_err=0, busy falls mid-stop-bit.
- Send 8'h3C then 8'hC3 back-to-back with no gap, acking 8'h3C before the second stop -> data=8'h3C then 8'hC3, no error pulses.
- 4-clock low glitch on RxD while idle (CLKS_PER_BIT=16) -> return to IDLE at the start-centre sample; rx_full stays 0, no flags.
- Frame 8'h55 with stop bit driven low, then line held low 3 bit times -> framing_err pulses exactly once, rx_full stays 0, receiver stays in BREAK until RxD returns high, then 8'h81 received correctly.
- Receive 8'h11 without ack, then 8'h22 -> overrun_err pulses once, data stays 8'h11; a later ack clears rx_full.
- Assert reset mid-DATA of 8'hF0 -> all outputs 0 immediately (async); next clean frame 8'h0F received correctly.

Source files
------------

// File: rtl/uart_receiver.sv
// uart_receiver
// Serial-to-parallel UART receiver for 8N1 frames (LSB first, idle-high line).
// The asynchronous RxD line passes through a two-flop synchroniser. The start
// bit is confirmed at its centre, and each data bit and the stop bit are then
// sampled at their bit centres. A received byte is held until the consumer
// acknowledges it. Framing and overrun conditions are flagged with one-cycle
// pulses.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   reset        asynchronous active-high reset
//   RxD          serial input, asynchronous to clk, idle high
//   data[7:0]    last accepted byte, stable while rx_full=1
//   rx_full      byte available, held until data_ack
//   data_ack     consumer acknowledge, clears rx_full on the same edge
//   framing_err  one-cycle pulse when the stop bit is sampled low
//   overrun_err  one-cycle pulse when a good byte is dropped because rx_full
//                is still set and no ack arrived
//   busy         high in every state except IDLE
module uart_receiver #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  output logic [7:0] data,
  output logic       rx_full,
  input  logic       data_ack,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          sync_p0;
  logic          rxd_s;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;

  logic          half_tick;
  logic          full_tick;
  logic          shift_en;
  logic          load_byte;
  logic          set_ovr;
  logic          set_frm;

  assign half_tick = (baud_cnt == HALF_LAST);
  assign full_tick = (baud_cnt == FULL_LAST);
  assign busy      = (state != IDLE);

  // Synchroniser: both flops reset high so the idle line is seen immediately
  // and no false start bit appears after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      rxd_s   <= 1'b1;
    end else begin
      sync_p0 <= RxD;
      rxd_s   <= sync_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    load_byte = 1'b0;
    set_ovr   = 1'b0;
    set_frm   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rxd_s) state_nx = START;
      end
      START: begin
        // A line that is high again at the start-bit centre was a glitch.
        if (half_tick) state_nx = rxd_s ? IDLE : DATA;
      end
      DATA: begin
        if (full_tick) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (full_tick) begin
          if (rxd_s) begin
            // An ack on this same edge frees the holding register in time.
            if (!rx_full || data_ack) load_byte = 1'b1;
            else                      set_ovr   = 1'b1;
            state_nx = IDLE;
          end else begin
            set_frm  = 1'b1;
            state_nx = BRK;
          end
        end
      end
      BRK: begin
        // A line held low must return high before a new start is accepted.
        if (rxd_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Baud counter restarts on every state change and wraps at each bit end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      baud_cnt <= '0;
    end else if (state_nx != state || state == IDLE || full_tick) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_idx   <= 3'd0;
      shift_reg <= 8'h00;
    end else begin
      if (state == START) begin
        bit_idx <= 3'd0;
      end else if (shift_en) begin
        bit_idx   <= bit_idx + 3'd1;
        shift_reg <= {rxd_s, shift_reg[7:1]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data        <= 8'h00;
      rx_full     <= 1'b0;
      framing_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      framing_err <= set_frm;
      overrun_err <= set_ovr;
      if (load_byte) begin
        data    <= shift_reg;
        rx_full <= 1'b1;
      end else if (data_ack) begin
        rx_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       RxD = 1'b1;
  logic [7:0] data;
  logic       rx_full;
  logic       data_ack = 1'b0;
  logic       framing_err;
  logic       overrun_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         rise_cnt = 0;
  logic [7:0] rise_byte = 8'h00;
  logic       full_q = 1'b0;

  int fe0, ov0, rise0;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .RxD        (RxD),
    .data       (data),
    .rx_full    (rx_full),
    .data_ack   (data_ack),
    .framing_err(framing_err),
    .overrun_err(overrun_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Event monitor sampled on the inactive edge.
  always @(negedge clk) begin
    if (framing_err === 1'b1) fe_cnt++;
    if (overrun_err === 1'b1) ov_cnt++;
    if (rx_full === 1'b1 && full_q === 1'b0) begin
      rise_cnt++;
      rise_byte = data;
    end
    full_q = rx_full;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic ack();
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; rise0 = rise_cnt;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", data, 8'h00);
    check("rst_full", rx_full, 0);
    check("rst_busy", busy, 0);
    check("rst_fe", framing_err, 0);
    check("rst_ov", overrun_err, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_busy", busy, 0);

    // Single frame 0xA5
    snap();
    send_bit(1'b0);
    send_bit(1'b1);
    check("a5_busy_mid", busy, 1);
    for (int i = 1; i < 8; i++) send_bit(8'hA5 >> i);
    send_bit(1'b1);
    check("a5_busy_after_stop", busy, 0);
    repeat (CPB) @(negedge clk);
    check("a5_rise", rise_cnt - rise0, 1);
    check("a5_data", data, 8'hA5);
    check("a5_full", rx_full, 1);
    check("a5_fe", fe_cnt - fe0, 0);
    check("a5_ov", ov_cnt - ov0, 0);
    ack();
    check("a5_ack_clears", rx_full, 0);
    check("a5_data_kept", data, 8'hA5);

    // Back-to-back 0x3C, 0xC3 with ack between
    snap();
    fork
      begin
        send_byte(8'h3C, 1'b1);
        send_byte(8'hC3, 1'b1);
      end
      begin
        for (int i = 0; i < 400 && rx_full !== 1'b1; i++) @(negedge clk);
        check("b2b_first_seen", rx_full, 1);
        check("b2b_first_data", data, 8'h3C);
        ack();
      end
    join
    repeat (CPB) @(negedge clk);
    check("b2b_rise", rise_cnt - rise0, 2);
    check("b2b_second_data", data, 8'hC3);
    check("b2b_full", rx_full, 1);
    check("b2b_fe", fe_cnt - fe0, 0);
    check("b2b_ov", ov_cnt - ov0, 0);
    ack();

    // Ack while empty is ignored
    ack();
    check("empty_ack_full", rx_full, 0);

    // 4-clock glitch
    snap();
    RxD = 1'b0;
    repeat (4) @(negedge clk);
    RxD = 1'b1;
    repeat (2) @(negedge clk);
    check("glitch_busy_start", busy, 1);
    repeat (12) @(negedge clk);
    check("glitch_busy_idle", busy, 0);
    check("glitch_full", rx_full, 0);
    check("glitch_rise", rise_cnt - rise0, 0);
    check("glitch_fe", fe_cnt - fe0, 0);
    check("glitch_ov", ov_cnt - ov0, 0);

    // Framing error then break, then good 0x81
    snap();
    send_byte(8'h55, 1'b0);
    repeat (3 * CPB) @(negedge clk);
    check("frm_fe", fe_cnt - fe0, 1);
    check("frm_full", rx_full, 0);
    check("frm_busy_break", busy, 1);
    check("frm_data_kept", data, 8'hC3);
    RxD = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("frm_busy_idle", busy, 0);
    send_byte(8'h81, 1'b1);
    repeat (CPB) @(negedge clk);
    check("frm_81_data", data, 8'h81);
    check("frm_81_full", rx_full, 1);
    check("frm_fe_once", fe_cnt - fe0, 1);
    ack();

    // Overrun
    snap();
    send_byte(8'h11, 1'b1);
    repeat (CPB) @(negedge clk);
    send_byte(8'h22, 1'b1);
    repeat (CPB) @(negedge clk);
    check("ovr_pulse", ov_cnt - ov0, 1);
    check("ovr_data", data, 8'h11);
    check("ovr_full", rx_full, 1);
    check("ovr_fe", fe_cnt - fe0, 0);
    ack();
    check("ovr_ack_clears", rx_full, 0);

    // Reset mid-DATA of 0xF0
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(8'hF0 >> i);
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_data", data, 8'h00);
    check("async_full", rx_full, 0);
    check("async_fe", framing_err, 0);
    check("async_ov", overrun_err, 0);
    RxD = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    snap();
    repeat (2 * CPB) @(negedge clk);
    send_byte(8'h0F, 1'b1);
    repeat (CPB) @(negedge clk);
    check("post_rst_data", data, 8'h0F);
    check("post_rst_full", rx_full, 1);
    check("post_rst_rise", rise_cnt - rise0, 1);
    check("post_rst_fe", fe_cnt - fe0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
